audio_out_i2s: RTL and testbench

Output stage that consumes the signed synthesis sample `sig` produced each `dspclk` by the sketch/voice stage and serialises it to an external I2S DAC. It generates BCLK/LRCLK from `dspclk`, latches one sample per frame (mono, duplicated to both channels) and applies a click-free soft-mute gain ramp. It sits between the synthesis core and the board's DAC pins.

---
 rtl/audio_out_pkg.sv | 20 ++
 rtl/audio_out_i2s_clkgen.sv | 51 +++++
 rtl/audio_out_i2s.sv | 116 +++++++++++
 tb/tb_audio_out_i2s.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_out_pkg.sv
// audio_out_pkg: shared state type and frame constants
// for the I2S output stage.
`ifndef BITS
`define BITS 16
`endif

package audio_out_pkg;

  typedef enum logic [1:0] {
    MUTED,
    RAMP_UP,
    RUN,
    RAMP_DOWN
  } gain_state_t;

  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS  = 32;
  localparam int GAIN_ONE   = 256;

endpackage

// File: rtl/audio_out_i2s_clkgen.sv
// i2s_clkgen: BCLK divider, 64-bit frame counter,
// word select and fall / frame-boundary strobes.
module i2s_clkgen #(
  parameter int BCLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_bclk,
  output logic o_lrclk,
  output logic o_fall,
  output logic o_frame
);

  localparam int DW = $clog2(BCLK_DIV);

  logic [DW-1:0] r_div;
  logic [5:0]    r_bcnt;
  logic          r_bclk;
  logic          r_lrclk;
  logic          w_tc;
  logic [5:0]    w_bcnt_nx;

  assign w_tc      = (r_div == DW'(BCLK_DIV - 1));
  assign w_bcnt_nx = r_bcnt + 6'd1;
  assign o_fall    = w_tc & r_bclk;
  // bcnt resets to 63 so the first fall is a boundary
  assign o_frame   = o_fall & (r_bcnt == 6'd63);
  assign o_bclk    = r_bclk;
  assign o_lrclk   = r_lrclk;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div   <= '0;
      r_bclk  <= 1'b0;
      r_lrclk <= 1'b0;
      r_bcnt  <= 6'd63;
    end else begin
      if (w_tc) begin
        r_div  <= '0;
        r_bclk <= ~r_bclk;
      end else begin
        r_div <= r_div + DW'(1);
      end
      if (o_fall) begin
        r_bcnt  <= w_bcnt_nx;
        r_lrclk <= w_bcnt_nx[5];
      end
    end
  end

endmodule

// File: rtl/audio_out_i2s.sv
// audio_out_i2s: mono sample to I2S DAC serialiser
// with a per-frame soft-mute gain ramp.
`ifndef BITS
`define BITS 16
`endif

module audio_out_i2s
  import audio_out_pkg::*;
#(
  parameter int W         = `BITS,
  parameter int BCLK_DIV  = 4,
  parameter int RAMP_STEP = 1
) (
  input  logic                dspclk,
  input  logic                rst,
  input  logic signed [W-1:0] sig,
  input  logic                mute,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdat,
  output logic                sample_req,
  output logic                muted
);

  logic w_fall;
  logic w_frame;

  gain_state_t r_state;
  logic [8:0]  r_gain;
  logic [FRAME_BITS-1:0] r_sh;
  logic        r_sdat;
  logic        r_req;
  logic        r_muted;

  logic [9:0]  w_sum;
  logic [8:0]  w_up;
  logic [8:0]  w_dn;
  logic [8:0]  w_gain_nx;
  logic signed [W+9:0] w_prod;
  logic signed [W-1:0] w_scaled;
  logic [SLOT_BITS-1:0] w_slot;

  i2s_clkgen #(
    .BCLK_DIV(BCLK_DIV)
  ) u_clkgen (
    .i_clk  (dspclk),
    .i_rst  (rst),
    .o_bclk (bclk),
    .o_lrclk(lrclk),
    .o_fall (w_fall),
    .o_frame(w_frame)
  );

  assign w_sum = {1'b0, r_gain} + 10'(RAMP_STEP);
  assign w_up  = (w_sum >= 10'(GAIN_ONE)) ?
                 9'(GAIN_ONE) : w_sum[8:0];
  assign w_dn  = (r_gain <= 9'(RAMP_STEP)) ?
                 9'd0 : r_gain - 9'(RAMP_STEP);

  always_comb begin
    w_gain_nx = r_gain;
    if (r_state == MUTED)
      w_gain_nx = 9'd0;
    else if (mute)
      w_gain_nx = w_dn;
    else
      w_gain_nx = w_up;
  end

  // gain is unsigned; a zero MSB keeps the product signed-correct
  assign w_prod   = sig * $signed({1'b0, w_gain_nx});
  assign w_scaled = W'(w_prod >>> 8);
  assign w_slot   = 32'({w_scaled, 32'd0} >> W);

  always_ff @(posedge dspclk) begin
    if (rst) begin
      r_state <= MUTED;
      r_gain  <= 9'd0;
      r_sh    <= '0;
      r_sdat  <= 1'b0;
      r_req   <= 1'b0;
      r_muted <= 1'b1;
    end else begin
      r_req <= w_frame;
      if (w_frame) begin
        r_gain <= w_gain_nx;
        r_sh   <= {w_slot, w_slot};
        r_sdat <= 1'b0;
        unique case (r_state)
          MUTED: begin
            if (!mute) r_state <= RAMP_UP;
            r_muted <= mute;
          end
          RAMP_UP, RUN, RAMP_DOWN: begin
            if (mute) begin
              r_state <= (w_dn == 9'd0) ? MUTED : RAMP_DOWN;
              r_muted <= (w_dn == 9'd0);
            end else begin
              r_state <= (w_up == 9'(GAIN_ONE)) ? RUN : RAMP_UP;
              r_muted <= 1'b0;
            end
          end
          default: r_state <= MUTED;
        endcase
      end else if (w_fall) begin
        r_sdat <= r_sh[FRAME_BITS-1];
        r_sh   <= {r_sh[FRAME_BITS-2:0], 1'b0};
      end
    end
  end

  assign sdat       = r_sdat;
  assign sample_req = r_req;
  assign muted      = r_muted;

endmodule

// File: tb/tb_audio_out_i2s.sv
// tb_audio_out_i2s: directed bench for the I2S output stage
// (W=16, BCLK_DIV=3, RAMP_STEP=4).
module tb_audio_out_i2s;

  localparam int DIV  = 3;
  localparam int STEP = 4;

  logic dspclk = 1'b0;
  logic rst    = 1'b1;
  logic mute   = 1'b0;
  logic signed [15:0] sig = 16'sh7FFF;
  logic bclk, lrclk, sdat, sample_req, muted;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t_req  = 0;
  int t_prev = 0;
  int lat    = 0;
  int t0, t1, t2, t3;
  logic [63:0] f, lr;

  audio_out_i2s #(
    .W(16), .BCLK_DIV(DIV), .RAMP_STEP(STEP)
  ) dut (
    .dspclk    (dspclk),
    .rst       (rst),
    .sig       (sig),
    .mute      (mute),
    .bclk      (bclk),
    .lrclk     (lrclk),
    .sdat      (sdat),
    .sample_req(sample_req),
    .muted     (muted)
  );

  always #5 dspclk = ~dspclk;
  always @(posedge dspclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  function automatic logic [15:0] sc(input int s, input int g);
    int p;
    p = s * g;
    return 16'(p >>> 8);
  endfunction

  task automatic chkw(input string tag, input logic [15:0] w);
    chk(tag, f, {w, 16'h0, w, 16'h0});
  endtask

  task automatic wait_req();
    bit got;
    got = 0;
    for (int i = 0; i < 4 * 128 * DIV; i++) begin
      @(negedge dspclk);
      if (sample_req === 1'b1) begin
        got = 1;
        break;
      end
    end
    if (!got) fail("req_timeout");
    t_prev = t_req;
    t_req  = cyc;
  endtask

  task automatic wait_fall();
    logic p;
    bit got;
    p = bclk;
    got = 0;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge dspclk);
      if (p === 1'b1 && bclk === 1'b0) begin
        got = 1;
        break;
      end
      p = bclk;
    end
    if (!got) fail("fall_timeout");
  endtask

  task automatic wait_rise(output int t);
    logic p;
    bit got;
    p = bclk;
    got = 0;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge dspclk);
      if (p === 1'b0 && bclk === 1'b1) begin
        got = 1;
        break;
      end
      p = bclk;
    end
    if (!got) fail("rise_timeout");
    t = cyc;
  endtask

  // starts in the sample_req cycle (bcnt=0)
  task automatic get_frame();
    f = '0;
    lr = '0;
    lr[0] = lrclk;
    chk("sdat_bcnt0", {63'b0, sdat}, 64'd0);
    for (int k = 1; k < 64; k++) begin
      wait_fall();
      if (k == 1) lat = cyc - t_req;
      f[64-k] = sdat;
      lr[k]   = lrclk;
    end
  endtask

  task automatic next_frame();
    wait_req();
    get_frame();
  endtask

  initial begin
    repeat (3) @(negedge dspclk);
    chk("rst_bclk",  {63'b0, bclk},       64'd0);
    chk("rst_lrclk", {63'b0, lrclk},      64'd0);
    chk("rst_sdat",  {63'b0, sdat},       64'd0);
    chk("rst_req",   {63'b0, sample_req}, 64'd0);
    chk("rst_muted", {63'b0, muted},      64'd1);

    rst = 1'b0;
    t0 = cyc;
    wait_req();
    chk("first_req", 64'(t_req - t0), 64'(2 * DIV));
    chk("muted_drop", {63'b0, muted}, 64'd0);
    get_frame();
    chkw("ramp_g0", 16'h0000);
    for (int k = 1; k <= 64; k++) begin
      next_frame();
      chkw("ramp_up", sc(32767, STEP * k));
    end
    next_frame();
    chkw("run_7fff", 16'h7FFF);

    sig = 16'sh8000;
    wait_req();
    chk("req_period", 64'(t_req - t_prev), 64'(128 * DIV));
    @(negedge dspclk);
    chk("req_width", {63'b0, sample_req}, 64'd0);
    get_frame();
    chk("run_8000", f, 64'h8000_0000_8000_0000);
    chk("lrclk_seq", lr, 64'hFFFF_FFFF_0000_0000);
    chk("msb_lat", 64'(lat), 64'(2 * DIV));
    chk("msb_bit", {63'b0, f[63]}, 64'd1);

    sig = 16'sh1234;
    wait_rise(t1);
    wait_fall();
    t2 = cyc;
    wait_rise(t3);
    chk("bclk_high", 64'(t2 - t1), 64'(DIV));
    chk("bclk_period", 64'(t3 - t1), 64'(2 * DIV));

    wait_req();
    repeat (50) @(negedge dspclk);
    mute = 1'b1;
    repeat (100) @(negedge dspclk);
    mute = 1'b0;
    next_frame();
    chkw("mute_pulse", 16'h1234);
    chk("mute_pulse_muted", {63'b0, muted}, 64'd0);

    sig = -16'sd256;
    mute = 1'b1;
    for (int g = 256 - STEP; g >= 100; g -= STEP) begin
      next_frame();
      chkw("ramp_down", sc(-256, g));
    end
    mute = 1'b0;
    next_frame();
    chkw("reverse_up", 16'(-104));
    next_frame();
    chkw("reverse_up2", 16'(-108));
    mute = 1'b1;
    for (int g = 104; g >= STEP; g -= STEP) begin
      next_frame();
      chkw("ramp_down2", sc(-256, g));
      chk("down_muted", {63'b0, muted}, 64'd0);
    end
    wait_req();
    chk("muted_rise", {63'b0, muted}, 64'd1);
    get_frame();
    chkw("muted_g0", 16'h0000);
    next_frame();
    chkw("muted_hold", 16'h0000);
    chk("muted_hold_flag", {63'b0, muted}, 64'd1);

    sig = 16'sh7FFF;
    mute = 1'b0;
    wait_req();
    chk("unmute_flag", {63'b0, muted}, 64'd0);
    get_frame();
    chkw("unmute_g0", 16'h0000);
    next_frame();
    chkw("unmute_g4", 16'h01FF);

    wait_req();
    for (int k = 0; k < 20; k++) wait_fall();
    repeat (DIV) @(negedge dspclk);
    chk("pre_rst_bclk", {63'b0, bclk}, 64'd1);
    rst = 1'b1;
    @(negedge dspclk);
    chk("mid_rst_bclk",  {63'b0, bclk},       64'd0);
    chk("mid_rst_lrclk", {63'b0, lrclk},      64'd0);
    chk("mid_rst_sdat",  {63'b0, sdat},       64'd0);
    chk("mid_rst_req",   {63'b0, sample_req}, 64'd0);
    chk("mid_rst_muted", {63'b0, muted},      64'd1);
    rst = 1'b0;
    t0 = cyc;
    wait_req();
    chk("post_rst_req", 64'(t_req - t0), 64'(2 * DIV));
    chk("post_rst_muted", {63'b0, muted}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
